// File: rtl/apb_completer_regs_pkg.sv
// Shared constants for the APB completer register bank: word offsets, CTRL bits,
// FSM encoding and the default ID.
package apb_completer_regs_pkg;

    // Word offsets, compared against PADDR[ADDRWIDTH-1:2]
    localparam int CTRL_OFS     = 0;
    localparam int SCRATCH0_OFS = 1;
    localparam int SCRATCH1_OFS = 2;
    localparam int COUNT_OFS    = 3;
    localparam int ID_OFS       = 4;

    localparam int CTRL_CNT_EN  = 0;
    localparam int CTRL_CNT_CLR = 1;

    localparam int WAIT_W = 4;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA2B0_0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_completer_regs_event.sv
// Free-running event counter qualified by the APB clock enable; clear beats increment.
module apb_event_counter #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pclken,
    input  logic                 en,
    input  logic                 clr,
    output logic [DATAWIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (pclken) begin
            if (clr) begin
                count <= '0;
            end else if (en) begin
                count <= count + DATAWIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer with CTRL/SCRATCH/COUNT/ID registers, parameterised wait states
// and PSLVERR on unmapped offsets or writes to read-only registers.
module apb_completer_regs
    import apb_completer_regs_pkg::*;
#(
    parameter int                   ADDRWIDTH   = 16,
    parameter int                   DATAWIDTH   = 32,
    parameter int                   WAIT_CYCLES = 0,
    parameter logic [DATAWIDTH-1:0] ID_VALUE    = DATAWIDTH'(ID_VALUE_DEFAULT)
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [DATAWIDTH-1:0] CNT_OUT
);

    state_t                 state, state_next;
    logic [ADDRWIDTH-3:0]   addr_q;
    logic                   write_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   cnt_en;
    logic [DATAWIDTH-1:0]   scratch0, scratch1, count, rdata;
    logic                   hit_ctrl, hit_s0, hit_s1, hit_count, hit_id, err;
    logic                   ready, setup, complete, do_write, cnt_clr;
    logic [1:0]             unused_addr_bits;

    assign unused_addr_bits = PADDR[1:0];

    // Decode works from the address latched in the setup phase, not the live bus
    assign hit_ctrl  = (addr_q == (ADDRWIDTH-2)'(CTRL_OFS));
    assign hit_s0    = (addr_q == (ADDRWIDTH-2)'(SCRATCH0_OFS));
    assign hit_s1    = (addr_q == (ADDRWIDTH-2)'(SCRATCH1_OFS));
    assign hit_count = (addr_q == (ADDRWIDTH-2)'(COUNT_OFS));
    assign hit_id    = (addr_q == (ADDRWIDTH-2)'(ID_OFS));
    assign err       = !(hit_ctrl || hit_s0 || hit_s1 || hit_count || hit_id)
                       || (write_q && (hit_count || hit_id));

    assign ready    = (state == ACCESS) && (wait_q == '0);
    assign setup    = PCLKEN && (state == IDLE) && PSEL && !PENABLE;
    assign complete = PCLKEN && ready && PSEL && PENABLE;
    assign do_write = complete && write_q && !err;
    assign cnt_clr  = do_write && hit_ctrl && PWDATA[CTRL_CNT_CLR];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (PSEL && !PENABLE) state_next = ACCESS;
            ACCESS: if (!PSEL || (PENABLE && ready)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wait_q  <= '0;
        end else if (PCLKEN) begin
            state <= state_next;
            if (setup) begin
                addr_q  <= PADDR[ADDRWIDTH-1:2];
                write_q <= PWRITE;
                wait_q  <= WAIT_W'(WAIT_CYCLES);
            end else if (state == ACCESS && wait_q != '0) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_en   <= 1'b0;
            scratch0 <= '0;
            scratch1 <= '0;
        end else if (do_write) begin
            if (hit_ctrl) cnt_en   <= PWDATA[CTRL_CNT_EN];
            if (hit_s0)   scratch0 <= PWDATA;
            if (hit_s1)   scratch1 <= PWDATA;
        end
    end

    apb_event_counter #(.DATAWIDTH(DATAWIDTH)) u_counter (
        .clk    (HCLK),
        .rst    (HRESET),
        .pclken (PCLKEN),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .count  (count)
    );

    // CNT_CLR is a strobe and always reads back as 0
    always_comb begin
        rdata = '0;
        if (hit_ctrl)  rdata[CTRL_CNT_EN] = cnt_en;
        if (hit_s0)    rdata = scratch0;
        if (hit_s1)    rdata = scratch1;
        if (hit_count) rdata = count;
        if (hit_id)    rdata = ID_VALUE;
    end

    assign PREADY  = ready;
    assign PSLVERR = ready && err;
    assign PRDATA  = (ready && !write_q && !err) ? rdata : '0;
    assign CNT_OUT = count;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench: three completers (0, 3 and 2 wait states) share one APB bus,
// each with its own PSEL, checked with immediate assertions.
module tb_apb_completer_regs;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PCLKEN;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        psel    [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] cnt_out [3];

    int errors = 0;
    int checks = 0;
    bit sparse = 0;

    always #5 HCLK = ~HCLK;

    apb_completer_regs #(.WAIT_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .CNT_OUT(cnt_out[0]));

    apb_completer_regs #(.WAIT_CYCLES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .CNT_OUT(cnt_out[1]));

    apb_completer_regs #(.WAIT_CYCLES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .CNT_OUT(cnt_out[2]));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next PCLKEN-qualified edge; sparse mode gives 1-in-4 enables
    task automatic pedge();
        if (sparse) begin
            PCLKEN = 1'b0;
            repeat (3) begin @(posedge HCLK); #1; end
        end
        PCLKEN = 1'b1;
        @(posedge HCLK); #1;
        if (sparse) PCLKEN = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] addr, input logic wr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int waits);
        psel[idx] = 1'b1; PENABLE = 1'b0;
        PADDR = addr; PWRITE = wr; PWDATA = wdata;
        pedge();
        PENABLE = 1'b1;
        waits = 0;
        while (pready[idx] !== 1'b1 && waits < 40) begin
            pedge();
            waits++;
        end
        checkOutput("pready_timeout", 32'(pready[idx]), 32'd1);
        rdata = prdata[idx];
        err   = pslverr[idx];
        pedge();
        psel[idx] = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        HRESET = 1'b1; PCLKEN = 1'b1; PENABLE = 1'b0;
        PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
        for (int i = 0; i < 3; i++) psel[i] = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("rst_pready",  32'(pready[0]),  32'd0);
        checkOutput("rst_pslverr", 32'(pslverr[0]), 32'd0);
        checkOutput("rst_prdata",  prdata[0],       32'd0);
        checkOutput("rst_cnt",     cnt_out[0],      32'd0);
        #3 HRESET = 1'b0;
        @(posedge HCLK); #1;

        applyStimulus(0, 16'h0010, 1'b0, 32'd0, rd, er, wt);
        checkOutput("id_data",  rd,      32'hA2B0_0001);
        checkOutput("id_err",   32'(er), 32'd0);
        checkOutput("id_waits", 32'(wt), 32'd0);

        applyStimulus(1, 16'h0008, 1'b1, 32'hDEAD_BEEF, rd, er, wt);
        checkOutput("s1_wr_waits", 32'(wt), 32'd3);
        checkOutput("s1_wr_err",   32'(er), 32'd0);
        applyStimulus(1, 16'h0008, 1'b0, 32'd0, rd, er, wt);
        checkOutput("s1_rd_waits", 32'(wt), 32'd3);
        checkOutput("s1_rd_data",  rd,      32'hDEAD_BEEF);

        applyStimulus(0, 16'h0000, 1'b1, 32'd1, rd, er, wt);
        repeat (10) pedge();
        checkOutput("cnt_after10", cnt_out[0], 32'd10);
        applyStimulus(0, 16'h000C, 1'b0, 32'd0, rd, er, wt);
        checkOutput("count_read", rd, 32'd11);
        applyStimulus(0, 16'h0000, 1'b1, 32'd3, rd, er, wt);
        checkOutput("cnt_cleared", cnt_out[0], 32'd0);
        pedge();
        checkOutput("cnt_resume", cnt_out[0], 32'd1);
        applyStimulus(0, 16'h0000, 1'b0, 32'd0, rd, er, wt);
        checkOutput("ctrl_read", rd, 32'd1);
        applyStimulus(0, 16'h0000, 1'b1, 32'd2, rd, er, wt);
        pedge();
        checkOutput("cnt_stopped", cnt_out[0], 32'd0);

        applyStimulus(0, 16'h000C, 1'b1, 32'h1234_5678, rd, er, wt);
        checkOutput("wr_count_err", 32'(er), 32'd1);
        applyStimulus(0, 16'h0010, 1'b1, 32'h1234_5678, rd, er, wt);
        checkOutput("wr_id_err", 32'(er), 32'd1);
        applyStimulus(0, 16'h000C, 1'b0, 32'd0, rd, er, wt);
        checkOutput("count_unchanged", rd, 32'd0);
        checkOutput("count_rd_err",    32'(er), 32'd0);
        applyStimulus(0, 16'h0020, 1'b0, 32'd0, rd, er, wt);
        checkOutput("unmapped_err",  32'(er), 32'd1);
        checkOutput("unmapped_data", rd,      32'd0);

        sparse = 1;
        psel[0] = 1'b1; PENABLE = 1'b0;
        PADDR = 16'h0004; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
        pedge();
        PENABLE = 1'b1;
        checkOutput("sparse_ready", 32'(pready[0]), 32'd1);
        repeat (3) begin @(posedge HCLK); #1; end
        checkOutput("sparse_hold", 32'(pready[0]), 32'd1);
        PCLKEN = 1'b1;
        @(posedge HCLK); #1;
        checkOutput("sparse_done", 32'(pready[0]), 32'd0);
        psel[0] = 1'b0; PENABLE = 1'b0;
        sparse = 0;
        applyStimulus(0, 16'h0004, 1'b0, 32'd0, rd, er, wt);
        checkOutput("s0_readback", rd, 32'hCAFE_F00D);

        psel[2] = 1'b1; PENABLE = 1'b0;
        PADDR = 16'h0004; PWRITE = 1'b1; PWDATA = 32'h55AA_55AA;
        pedge();
        PENABLE = 1'b1;
        checkOutput("rw_wait_lo", 32'(pready[2]), 32'd0);
        pedge();
        pedge();
        checkOutput("rw_ready", 32'(pready[2]), 32'd1);
        #2 HRESET = 1'b1;
        #1;
        checkOutput("rw_pready_drop",  32'(pready[2]),  32'd0);
        checkOutput("rw_pslverr_drop", 32'(pslverr[2]), 32'd0);
        psel[2] = 1'b0; PENABLE = 1'b0;
        #2 HRESET = 1'b0;
        @(posedge HCLK); #1;
        applyStimulus(2, 16'h0004, 1'b0, 32'd0, rd, er, wt);
        checkOutput("rw_discarded", rd,      32'd0);
        checkOutput("rw_rd_waits",  32'(wt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
